muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV64 M-extension multiply/divide unit in the EX stage.
- Produces mult_ok, the ready signal the hazard unit consumes. The hazard unit drives stallE/flushM from mult_ok and returns stall and flush back to this unit.
- Holds the pipeline through a multi-cycle operation.
- Holds its result stable until the EX stage advances.

Parameters:
- XLEN, 64, operand/result width; must be even and ≥ 8.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- valid_i  in  1  EX instruction is an M-ext op
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- word_i  in  1  *W variant (used only with MULDIV_WORD_OP_EN)
- a_i  in  XLEN  rs1 operand
- b_i  in  XLEN  rs2 operand
- stall_i  in  1  EX held this cycle (stallE from hazard unit)
- flush_i  in  1  kill current EX instruction
- mult_ok_o  out  1  low while an operation is pending; drives hazard unit
- result_o  out  XLEN  result; valid in DONE
- busy_o  out  1  state == BUSY

Behaviour:
- Reset (async, resetn=0): state IDLE, counter 0, internal accumulators 0, result_o 0, busy_o 0.
- States: IDLE, BUSY, DONE.
- mult_ok_o is combinational:
  - 0 when (IDLE & valid_i & ~flush_i) or BUSY.
  - Otherwise 1, including during reset.
  - The same-cycle low is required so the hazard unit stalls the issuing cycle.
- IDLE, valid_i & ~flush_i:
  - Capture operands into sign-corrected magnitudes per op: MULH signed×signed, MULHSU signed×unsigned, MULHU/DIVU/REMU unsigned, DIV/REM signed.
  - Record the result sign.
  - Special divide cases go directly to DONE (mult_ok_o low 1 cycle only):
    - b=0: DIV/DIVU → all ones; REM/REMU → a.
    - Signed overflow (a = most negative, b = −1): DIV → a; REM → 0.
  - Otherwise → BUSY with counter = XLEN.
- BUSY:
  - Multiply: radix-2 shift-add, one multiplier bit per cycle, 2·XLEN-bit product.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements; at counter==1 → DONE, applying sign correction and selecting low/high product, quotient or remainder.
  - Total mult_ok_o-low time for a normal op: XLEN+1 cycles (issue cycle + XLEN BUSY cycles).
- DONE:
  - result_o valid and stable; mult_ok_o = 1.
  - If stall_i: stay in DONE, do not restart, even though valid_i remains high.
  - If ~stall_i: → IDLE (instruction advances this edge).
- flush_i in any state → IDLE next edge.
  - An issue is suppressed in the flush cycle.
  - Partial results are discarded; result_o is not updated by an aborted op.
- flush_i and stall_i both high: flush wins.
- Reset mid-operation: immediately IDLE, mult_ok_o 1.
- result_o holds its last value outside DONE.
- All arithmetic is modulo 2^XLEN; no exceptions raised.

Optional Feature:
- MULDIV_WORD_OP_EN defined:
  - word_i=1 selects MULW/DIVW/DIVUW/REMW/REMUW.
  - Operands are the low 32 bits (sign- or zero-extended per op).
  - Iteration count is 32, so a normal op has mult_ok_o low for 33 cycles.
  - Result is the low 32 bits sign-extended to XLEN.
  - Special cases use 32-bit semantics: overflow uses 0x8000_0000 / −1; b[31:0]=0 is divide by zero.
- Undefined: word_i ignored; all ops full XLEN.

Test Plan:
- MUL a=7, b=−3 → mult_ok_o low exactly 65 cycles from issue, then result_o=0xFFFF_FFFF_FFFF_FFEB; MULHU a=b=all ones → 0xFFFF_FFFF_FFFF_FFFE.
- DIV a=−7, b=2 → 0xFFFF_FFFF_FFFF_FFFD; REM same operands → 0xFFFF_FFFF_FFFF_FFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU a=0x1234, b=0 → all ones, mult_ok_o low 1 cycle only; REMU same operands → 0x1234; DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000; REM same operands → 0.
- MUL issued, flush_i at BUSY cycle 10 → IDLE next edge, mult_ok_o 1, result_o unchanged; next MUL 3×5 → 15 after full latency.
- DONE reached with stall_i held 3 cycles and valid_i high → result_o stable, mult_ok_o 1, no restart, busy_o 0; stall_i drops → IDLE; back-to-back op issues next cycle.
- With MULDIV_WORD_OP_EN: MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE after 33 low cycles; DIVW 0x8000_0000 / −1 → 0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_WORD_OP_EN to enable the 32-bit *W variants selected by word_i.
module muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            mult_ok_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   result_q, result_d;

`ifdef MULDIV_WORD_OP_EN
  logic word_q, word_d;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction
`else
  logic unused_word;
  assign unused_word = word_i;
`endif

  // Issue-time operand conditioning and special-case detection
  logic            issue, is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, int_min, dividend, spec_res;
  logic [CntW-1:0] iter_cnt;

  always_comb begin
    issue    = valid_i & ~flush_i;
    is_div   = op_i[2];
    a_sgn    = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn    = is_div ? ~op_i[0] : ~op_i[1];
    a_ext    = a_i;
    b_ext    = b_i;
    int_min  = {1'b1, {(XLEN-1){1'b0}}};
    iter_cnt = CntW'(XLEN);
`ifdef MULDIV_WORD_OP_EN
    if (word_i) begin
      a_ext    = {{(XLEN-32){a_sgn & a_i[31]}}, a_i[31:0]};
      b_ext    = {{(XLEN-32){b_sgn & b_i[31]}}, b_i[31:0]};
      int_min  = {{(XLEN-31){1'b1}}, 31'b0};
      iter_cnt = CntW'(32);
    end
`endif
    a_neg    = a_sgn & a_ext[XLEN-1];
    b_neg    = b_sgn & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    dividend = a_mag;
`ifdef MULDIV_WORD_OP_EN
    // Left-align the 32-bit dividend so 32 iterations consume all of it
    if (word_i) dividend = {a_mag[31:0], {(XLEN-32){1'b0}}};
`endif
    b_zero   = (b_ext == '0);
    ovf      = is_div & ~op_i[0] & (a_ext == int_min) & (b_ext == '1);
    special  = is_div & (b_zero | ovf);
    if (b_zero) spec_res = op_i[1] ? a_ext : '1;
    else        spec_res = op_i[1] ? '0 : a_ext;
`ifdef MULDIV_WORD_OP_EN
    if (word_i) spec_res = sext32(spec_res);
`endif
  end

  // One iteration of each algorithm plus the final sign-corrected result
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_bit;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, mul_p, mul_c;
  logic [XLEN-1:0]   div_v, div_c, fin_res;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt  = {mul_sum, prod_q[XLEN-1:1]};
    div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_bit  = ~div_diff[XLEN];
    div_nxt  = {(div_bit ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), prod_q[XLEN-2:0], div_bit};
    mul_p    = mul_nxt;
`ifdef MULDIV_WORD_OP_EN
    // After 32 iterations the product sits XLEN-32 bits above its natural position
    if (word_q) mul_p = mul_nxt >> (XLEN - 32);
`endif
    mul_c    = neg_q ? -mul_p : mul_p;
    div_v    = op_q[1] ? div_nxt[2*XLEN-1:XLEN] : div_nxt[XLEN-1:0];
    div_c    = neg_q ? -div_v : div_v;
    if (op_q[2])               fin_res = div_c;
    else if (op_q[1:0] == 2'b00) fin_res = mul_c[XLEN-1:0];
    else                       fin_res = mul_c[2*XLEN-1:XLEN];
`ifdef MULDIV_WORD_OP_EN
    if (word_q) fin_res = sext32(fin_res);
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    result_d = result_q;
`ifdef MULDIV_WORD_OP_EN
    word_d   = word_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          op_d   = op_i;
          neg_d  = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);
          opnd_d = is_div ? b_mag : a_mag;
          prod_d = {{XLEN{1'b0}}, (is_div ? dividend : b_mag)};
          cnt_d  = iter_cnt;
`ifdef MULDIV_WORD_OP_EN
          word_d = word_i;
`endif
          if (special) begin
            result_d = spec_res;
            state_d  = StDone;
          end else begin
            state_d  = StBusy;
          end
        end
      end
      StBusy: begin
        prod_d = op_q[2] ? div_nxt : mul_nxt;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          result_d = fin_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (!stall_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush beats stall and discards any in-flight result
    if (flush_i) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
`ifdef MULDIV_WORD_OP_EN
      word_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      result_q <= result_d;
`ifdef MULDIV_WORD_OP_EN
      word_q   <= word_d;
`endif
    end
  end

  // Low in the issue cycle itself so the hazard unit stalls that same cycle
  assign mult_ok_o = ~resetn | ~(((state_q == StIdle) & issue) | (state_q == StBusy));
  assign busy_o    = (state_q == StBusy);
  assign result_o  = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN = 64).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic        word_i = 1'b0;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        mult_ok_o;
  logic [63:0] result_o;
  logic        busy_o;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.XLEN(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid_i   (valid_i),
    .op_i      (op_i),
    .word_i    (word_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .mult_ok_o (mult_ok_o),
    .result_o  (result_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Issue one op, count mult_ok_o-low cycles until DONE, then check result and busy_o
  task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input logic hold,
                        input int exp_low, input logic [63:0] exp_res);
    int low;
    low = 0;
    @(negedge clk);
    valid_i = 1'b1; op_i = op; word_i = word; a_i = a; b_i = b;
    stall_i = hold; flush_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (mult_ok_o) break;
      low++;
      @(negedge clk);
    end
    check({tag, " latency"}, 64'(low), 64'(exp_low));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    // Reset with valid_i high: mult_ok_o must still read 1
    resetn = 1'b0; valid_i = 1'b1; a_i = 64'd5; b_i = 64'd5;
    #12;
    check("reset mult_ok", 64'(mult_ok_o), 64'd1);
    check("reset result", result_o, 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    valid_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    run_op("mul 7*-3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65,
           64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mulhu ones", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65,
           64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu -2*ones", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           65, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulh -1*3", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 65,
           64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div -7/2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 65,
           64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem -7/2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 65,
           64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divu 100/7", 3'd5, 1'b0, 64'd100, 64'd7, 1'b0, 65, 64'd14);
    run_op("remu 100/7", 3'd7, 1'b0, 64'd100, 64'd7, 1'b0, 65, 64'd2);

    run_op("divu by0", 3'd5, 1'b0, 64'h1234, 64'd0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1,
           64'h8000_0000_0000_0000);
    run_op("rem ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1,
           64'd0);
    run_op("remu by0", 3'd7, 1'b0, 64'h1234, 64'd0, 1'b0, 1, 64'h1234);

    // Flush in the issue cycle suppresses the issue
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; a_i = 64'd3; b_i = 64'd5;
    #1;
    check("flush issue mult_ok", 64'(mult_ok_o), 64'd1);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flush issue busy", 64'(busy_o), 64'd0);

    // Flush at BUSY cycle 10 aborts without touching result_o
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd0; a_i = 64'd11; b_i = 64'd13;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    #1;
    check("busy before flush", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    check("flush mult_ok", 64'(mult_ok_o), 64'd1);
    check("flush busy", 64'(busy_o), 64'd0);
    check("flush result", result_o, 64'h1234);
    @(negedge clk);
    #1;
    check("flush result later", result_o, 64'h1234);

    run_op("mul 3*5", 3'd0, 1'b0, 64'd3, 64'd5, 1'b0, 65, 64'd15);

    // DONE held by stall with valid_i still high
    run_op("mul stall", 3'd0, 1'b0, 64'd6, 64'd7, 1'b1, 65, 64'd42);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("stall result", result_o, 64'd42);
      check("stall mult_ok", 64'(mult_ok_o), 64'd1);
      check("stall busy", 64'(busy_o), 64'd0);
    end
    stall_i = 1'b0;
    run_op("b2b divu", 3'd5, 1'b0, 64'd1000, 64'd10, 1'b0, 65, 64'd100);

    // Asynchronous reset mid-operation
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd0; a_i = 64'd3; b_i = 64'd3;
    for (int k = 0; k < 5; k++) @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midreset mult_ok", 64'(mult_ok_o), 64'd1);
    check("midreset busy", 64'(busy_o), 64'd0);
    check("midreset result", result_o, 64'd0);
    valid_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

`ifdef MULDIV_WORD_OP_EN
    run_op("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 1'b0, 33, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divw ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1,
           64'hFFFF_FFFF_8000_0000);
    run_op("divw -7/2", 3'd4, 1'b1, 64'hFFFF_FFF9, 64'd2, 1'b0, 33, 64'hFFFF_FFFF_FFFF_FFFD);
`endif

    @(negedge clk);
    valid_i = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
